jtag_chain_mux: RTL
===================

Name: jtag_chain_mux

Overview:
- Parametrised N-channel JTAG router between one virtual JTAG master (V_*) and N target TAPs.
- Any subset of channels can be selected. The selected channels are daisy-chained in ascending index order; unselected channels are parked.
- Selection changes are requested from the CLK domain by handshake. They are applied only at a JTAG-safe point, tracked by an internal shadow TAP state machine.
- Sits between the host JTAG bridge and the board's per-device JTAG pins.

Parameters:
- N_CHAN, 12, number of target channels (1..32).
- RESET_MASK, 12'h001, ACTIVE_MASK value after reset.
- IDLE_CYCLES, 16, consecutive CLK cycles with TCK low that count as a quiet bus.
- TIMEOUT, 65535, CLK cycles a pending request may wait before it is abandoned.

Ports:
- CLK  input  1  system clock; must be at least 4x the V_TCK frequency.
- RST  input  1  asynchronous, active-high reset.
- SEL_REQ  input  1  one-cycle request to load SEL_MASK.
- SEL_MASK  input  N_CHAN  requested channel set; sampled when SEL_REQ=1.
- SEL_BUSY  output  1  a request is pending.
- SEL_ACK  output  1  one-cycle pulse when the new mask takes effect.
- SEL_ERR  output  1  one-cycle pulse when a pending request times out.
- ACTIVE_MASK  output  N_CHAN  currently applied channel set.
- TAP_STATE  output  4  shadow TAP state (package encoding).
- V_TDI, V_TMS, V_TCK  input  1  from the master; asynchronous to CLK.
- V_TDO  output  1  to the master.
- TDI  output  N_CHAN  per-target TDI.
- TCK  output  N_CHAN  per-target gated TCK.
- TMS  output  1  shared TMS.
- TDO  input  N_CHAN  per-target TDO.

Behaviour:
- Reset values:
  - ACTIVE_MASK=RESET_MASK, TAP_STATE=TLR.
  - SEL_BUSY, SEL_ACK, SEL_ERR = 0.
  - Ctrl FSM=IDLE, all counters 0.
- Data path (combinational, no CLK latency):
  - TMS=V_TMS.
  - Active channel i: TCK[i]=V_TCK.
  - Inactive channel: TCK[i]=0, TDI[i]=0.
  - Chain, for active channels a0<a1<...<ak:
    - TDI[a0]=V_TDI.
    - TDI[a(j+1)]=TDO[aj].
    - V_TDO=TDO[ak].
  - ACTIVE_MASK=0: V_TDO=0, all TCK low.
- Synchronisers:
  - V_TCK and V_TMS each pass through 2 flops, plus 1 extra TCK stage for edge detection.
  - A TCK rising edge is (s2 & ~s3). TMS is sampled from its s2 on that edge.
- Shadow TAP: the 16-state IEEE 1149.1 FSM, advanced once per detected rising edge.
- Quiet counter:
  - Counts CLK cycles while synchronised TCK=0 and no edge occurs.
  - Clears on TCK=1.
  - Saturates at IDLE_CYCLES.
  - safe = (quiet==IDLE_CYCLES) & (TAP_STATE is TLR or RTI).
- Ctrl FSM:
  - IDLE:
    - SEL_REQ=1: pend<=SEL_MASK, SEL_BUSY<=1, timer<=0, go to PEND.
  - PEND:
    - SEL_REQ=1 overwrites pend and restarts the timer. No extra ACK is issued.
    - safe=1: ACTIVE_MASK<=pend, SEL_ACK pulse, SEL_BUSY<=0, go to IDLE. The mask is applied the cycle after safe is seen.
    - Otherwise, when timer reaches TIMEOUT: SEL_ERR pulse, pend discarded, SEL_BUSY<=0, go to IDLE.
    - If safe and timeout occur in the same cycle, safe wins.
  - Same-mask request: still waits for safe, then ACKs.
- Reset mid-operation: the pending request is lost, the mask reverts to RESET_MASK and the shadow returns to TLR.
- Five consecutive TMS=1 edges force the shadow to TLR from any state.

Decomposition:
- Package jtag_pkg holds:
  - 4-bit tap_state_t enum (TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15).
  - tap_next(state, tms) function.
- One sub-module: jtag_tap_shadow.
  - Contains the synchronisers, edge detect, shadow FSM and quiet counter.
  - Outputs TAP_STATE and safe.
- The chain router is a generate loop in the top module.

Test Plan:
- Reset with RESET_MASK=12'h001:
  - ACTIVE_MASK=0x001, TAP_STATE=0.
  - V_TDI toggles appear on TDI[0]; TDI[11:1]=0, TCK[11:1]=0; V_TDO follows TDO[0].
- TCK idle in RTI, SEL_REQ with 0x00A:
  - After IDLE_CYCLES quiet cycles: ACK pulse, ACTIVE_MASK=0x00A.
  - V_TDI reaches TDI[1]; TDO[1] reaches TDI[3]; V_TDO=TDO[3]; TCK[0]=0.
- Master in SH_DR, TCK stopped, SEL_REQ with 0x004:
  - SEL_BUSY stays 1 and no ACK is issued.
  - Clock TMS 1,1,0 (EX1_DR→UPD_DR→RTI), then idle: ACK, ACTIVE_MASK=0x004.
- TIMEOUT=100, master parked in PA_IR:
  - SEL_ERR pulses at 100 cycles, ACTIVE_MASK is unchanged, BUSY=0.
- Two SEL_REQs (0x010 then 0x020) while pending:
  - Exactly one ACK; final ACTIVE_MASK=0x020.
- Mask 0x000 applied:
  - V_TDO=0 and all TCK=0.
- RST asserted mid-pending:
  - Immediately BUSY=0, ACTIVE_MASK=0x001, TAP_STATE=TLR.

Source files
------------

// File: rtl/jtag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_pkg                                                           |
// | IEEE 1149.1 TAP state encoding and next-state function.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PA_DR  = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PA_IR  = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        nxt = TLR;
        case (state)
            TLR:     nxt = tms ? TLR    : RTI;
            RTI:     nxt = tms ? SEL_DR : RTI;
            SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
            SH_DR:   nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:  nxt = tms ? UPD_DR : PA_DR;
            PA_DR:   nxt = tms ? EX2_DR : PA_DR;
            EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:  nxt = tms ? SEL_DR : RTI;
            SEL_IR:  nxt = tms ? TLR    : CAP_IR;
            CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
            SH_IR:   nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:  nxt = tms ? UPD_IR : PA_IR;
            PA_IR:   nxt = tms ? EX2_IR : PA_IR;
            EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:  nxt = tms ? SEL_DR : RTI;
            default: nxt = TLR;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_shadow.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_tap_shadow                                                    |
// | Tracks the master's TAP state in the CLK domain; flags quiet bus.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtag_tap_shadow
    import jtag_pkg::*;
#(
    parameter int IDLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       v_tck,
    input  logic       v_tms,
    output tap_state_t tap_state,
    output logic       safe
);

    localparam int QW = $clog2(IDLE_CYCLES + 1);

    logic             r_tck_s1;
    logic             r_tck_s2;
    logic             r_tck_s3;
    logic             r_tms_s1;
    logic             r_tms_s2;
    logic [QW-1:0]    r_quiet;
    tap_state_t       r_state;
    logic             w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tck_s1 <= 1'b0;
            r_tck_s2 <= 1'b0;
            r_tck_s3 <= 1'b0;
            r_tms_s1 <= 1'b0;
            r_tms_s2 <= 1'b0;
        end else begin
            r_tck_s1 <= v_tck;
            r_tck_s2 <= r_tck_s1;
            r_tck_s3 <= r_tck_s2;
            r_tms_s1 <= v_tms;
            r_tms_s2 <= r_tms_s1;
        end
    end

    // TMS shares the TCK sync depth, so s2 of TMS is aligned with the edge
    assign w_rise = r_tck_s2 & ~r_tck_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TLR;
        end else if (w_rise) begin
            r_state <= tap_next(r_state, r_tms_s2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quiet <= '0;
        end else if (r_tck_s2) begin
            r_quiet <= '0;
        end else if (r_quiet != QW'(IDLE_CYCLES)) begin
            r_quiet <= r_quiet + QW'(1);
        end
    end

    assign tap_state = r_state;
    assign safe      = (r_quiet == QW'(IDLE_CYCLES)) && ((r_state == TLR) || (r_state == RTI));

endmodule
`default_nettype wire

// File: rtl/jtag_chain_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_chain_mux                                                     |
// | N-channel JTAG daisy-chain router with safe-point mask switching.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtag_chain_mux
    import jtag_pkg::*;
#(
    parameter int                N_CHAN      = 12,
    parameter logic [N_CHAN-1:0] RESET_MASK  = N_CHAN'(1),
    parameter int                IDLE_CYCLES = 16,
    parameter int                TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_req,
    input  logic [N_CHAN-1:0] sel_mask,
    output logic              sel_busy,
    output logic              sel_ack,
    output logic              sel_err,
    output logic [N_CHAN-1:0] active_mask,
    output logic [3:0]        tap_state,
    input  logic              v_tdi,
    input  logic              v_tms,
    input  logic              v_tck,
    output logic              v_tdo,
    output logic [N_CHAN-1:0] tdi,
    output logic [N_CHAN-1:0] tck,
    output logic              tms,
    input  logic [N_CHAN-1:0] tdo
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_PEND = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [N_CHAN-1:0] r_pend;
    logic [N_CHAN-1:0] r_active;
    logic [TW-1:0]     r_timer;
    logic              r_ack;
    logic              r_err;
    logic              w_safe;
    logic              w_load;
    logic              w_apply;
    logic              w_expire;
    tap_state_t        w_tap_state;

    jtag_tap_shadow #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .v_tck     (v_tck),
        .v_tms     (v_tms),
        .tap_state (w_tap_state),
        .safe      (w_safe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A fresh request takes precedence so the newest mask is never dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (sel_req) w_state_nxt = ST_PEND;
            ST_PEND: begin
                if (sel_req)                              w_state_nxt = ST_PEND;
                else if (w_safe)                          w_state_nxt = ST_IDLE;
                else if (r_timer == TW'(TIMEOUT))         w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load   = sel_req;
        w_apply  = (r_state == ST_PEND) && !sel_req && w_safe;
        w_expire = (r_state == ST_PEND) && !sel_req && !w_safe && (r_timer == TW'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend   <= '0;
            r_timer  <= '0;
            r_active <= RESET_MASK;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_load) begin
                r_pend  <= sel_mask;
                r_timer <= '0;
            end else if (r_state == ST_PEND) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_apply) begin
                r_active <= r_pend;
            end
            r_ack <= w_apply;
            r_err <= w_expire;
        end
    end

    assign sel_busy    = (r_state == ST_PEND);
    assign sel_ack     = r_ack;
    assign sel_err     = r_err;
    assign active_mask = r_active;
    assign tap_state   = w_tap_state;
    assign tms         = v_tms;

    // Each stage forwards either its own TDO (active) or the upstream link
    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
        logic w_in;
        logic w_out;
        if (i == 0) begin : g_first
            assign w_in = v_tdi;
        end else begin : g_next
            assign w_in = g_chan[i-1].w_out;
        end
        assign w_out  = r_active[i] ? tdo[i] : w_in;
        assign tdi[i] = r_active[i] & w_in;
        assign tck[i] = r_active[i] & v_tck;
    end

    assign v_tdo = (|r_active) & g_chan[N_CHAN-1].w_out;

endmodule
`default_nettype wire
